// File: rtl/full_adder_reg.sv
// Registered ripple-carry adder: S/Co = A + B + Ci, captured one cycle after in_valid.
// Define FULL_ADDER_OVF_EN to add the registered signed-overflow output Ov.

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

module full_adder_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    output logic [WIDTH-1:0] S,
    output logic             Co,
`ifdef FULL_ADDER_OVF_EN
    output logic             Ov,
`endif
    output logic             out_valid
);

    logic [WIDTH-1:0] a_gated;
    logic [WIDTH-1:0] b_gated;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   carry;

    // Operands are forced to zero when not qualified so unknowns on an idle bus stay out of the chain.
    assign a_gated  = A & {WIDTH{in_valid}};
    assign b_gated  = B & {WIDTH{in_valid}};
    assign carry[0] = Ci & in_valid;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a  (a_gated[i]),
            .b  (b_gated[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            S         <= '0;
            Co        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                S  <= sum;
                Co <= carry[WIDTH];
            end
        end
    end

`ifdef FULL_ADDER_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            Ov <= 1'b0;
        end else if (in_valid) begin
            Ov <= carry[WIDTH] ^ carry[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_full_adder_reg.sv
// Directed bench for full_adder_reg: a WIDTH=1 and a WIDTH=8 instance share clock and reset.
// Ov checks are compiled in when FULL_ADDER_OVF_EN is defined.

module tb_full_adder_reg;

    typedef struct {
        logic a;
        logic b;
        logic ci;
        logic s;
        logic co;
    } bit_vec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] s;
        logic       co;
    } byte_vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       v1, a1, b1, c1, s1, co1, ov1, ovalid1;
    logic       v8, c8, co8, ov8, ovalid8;
    logic [7:0] a8, b8, s8;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    full_adder_reg #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v1),
        .A         (a1),
        .B         (b1),
        .Ci        (c1),
        .S         (s1),
        .Co        (co1),
`ifdef FULL_ADDER_OVF_EN
        .Ov        (ov1),
`endif
        .out_valid (ovalid1)
    );

    full_adder_reg #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v8),
        .A         (a8),
        .B         (b8),
        .Ci        (c8),
        .S         (s8),
        .Co        (co8),
`ifdef FULL_ADDER_OVF_EN
        .Ov        (ov8),
`endif
        .out_valid (ovalid8)
    );

`ifndef FULL_ADDER_OVF_EN
    assign ov1 = 1'b0;
    assign ov8 = 1'b0;
`endif

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one edge and settle, so outputs reflect what that edge captured.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic ci);
        v8 = v;
        a8 = a;
        b8 = b;
        c8 = ci;
    endtask

    initial begin
        bit_vec_t  tt[8];
        byte_vec_t wv[3];

        tt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tt[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tt[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tt[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tt[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tt[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tt[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tt[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        wv[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        wv[1] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
        wv[2] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

        // Reset held two cycles while inputs are presented.
        rst = 1'b1;
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
        apply_stimulus8(1'b1, 8'h01, 8'h01, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_output("rst_s1", s1, 0);
            check_output("rst_co1", co1, 0);
            check_output("rst_valid1", ovalid1, 0);
            check_output("rst_s8", s8, 0);
            check_output("rst_valid8", ovalid8, 0);
`ifdef FULL_ADDER_OVF_EN
            check_output("rst_ov8", ov8, 0);
`endif
        end
        rst = 1'b0;
        v1 = 1'b0;
        v8 = 1'b0;
        tick();
        check_output("post_rst_s1", s1, 0);
        check_output("post_rst_co1", co1, 0);
        check_output("post_rst_valid1", ovalid1, 0);

        // WIDTH=1 truth table, back-to-back.
        for (int i = 0; i < 8; i++) begin
            v1 = 1'b1;
            a1 = tt[i].a;
            b1 = tt[i].b;
            c1 = tt[i].ci;
            tick();
            check_output($sformatf("tt%0d_s", i), s1, tt[i].s);
            check_output($sformatf("tt%0d_co", i), co1, tt[i].co);
            check_output($sformatf("tt%0d_valid", i), ovalid1, 1);
        end
        v1 = 1'b0;
        tick();
        check_output("tt_idle_valid", ovalid1, 0);
        check_output("tt_idle_s", s1, 1);

        // WIDTH=8 wrap-around vectors, back-to-back.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus8(1'b1, wv[i].a, wv[i].b, wv[i].ci);
            tick();
            check_output($sformatf("wrap%0d_s", i), s8, wv[i].s);
            check_output($sformatf("wrap%0d_co", i), co8, wv[i].co);
            check_output($sformatf("wrap%0d_valid", i), ovalid8, 1);
        end

        // Hold: idle cycles with garbage, including unknowns, on the operands.
        apply_stimulus8(1'b1, 8'h0F, 8'h01, 1'b0);
        tick();
        check_output("hold_cap_s", s8, 8'h10);
        check_output("hold_cap_valid", ovalid8, 1);
        apply_stimulus8(1'b0, 8'hFF, 8'hFF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output($sformatf("hold%0d_s", i), s8, 8'h10);
            check_output($sformatf("hold%0d_co", i), co8, 0);
            check_output($sformatf("hold%0d_valid", i), ovalid8, 0);
        end
        apply_stimulus8(1'b0, 8'hxx, 8'hxx, 1'bx);
        tick();
        check_output("xsafe_s", s8, 8'h10);
        check_output("xsafe_co", co8, 0);

        // Reset in the middle of a continuous stream.
        apply_stimulus8(1'b1, 8'h05, 8'h03, 1'b0);
        tick();
        check_output("mid_pre_s", s8, 8'h08);
        rst = 1'b1;
        tick();
        check_output("mid_rst_s", s8, 0);
        check_output("mid_rst_co", co8, 0);
        check_output("mid_rst_valid", ovalid8, 0);
        rst = 1'b0;
        tick();
        check_output("mid_post_s", s8, 8'h08);
        check_output("mid_post_valid", ovalid8, 1);

`ifdef FULL_ADDER_OVF_EN
        // Signed overflow flag.
        apply_stimulus8(1'b1, 8'h7F, 8'h01, 1'b0);
        tick();
        check_output("ovf0_s", s8, 8'h80);
        check_output("ovf0_co", co8, 0);
        check_output("ovf0_ov", ov8, 1);
        apply_stimulus8(1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        check_output("ovf_hold_ov", ov8, 1);
        apply_stimulus8(1'b1, 8'hFF, 8'h01, 1'b0);
        tick();
        check_output("ovf1_s", s8, 8'h00);
        check_output("ovf1_co", co8, 1);
        check_output("ovf1_ov", ov8, 0);
        v1 = 1'b1; a1 = 1'b0; b1 = 1'b0; c1 = 1'b1;
        tick();
        check_output("ovf_w1_ov", ov1, 1);
        v1 = 1'b0;
`endif

        v8 = 1'b0;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/full_adder_reg.md
Name: full_adder_reg

Overview:
- Parameterized registered binary adder built from a chain of 1-bit full-adder cells.
- Computes A + B + Ci and registers the sum S and carry-out Co one clock after an input is accepted.
- Default WIDTH=1 gives a clocked single-bit full adder.
- Serves as the arithmetic primitive for datapath blocks that need a registered add with carry-in/carry-out.

Parameters:
- WIDTH, 1, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  qualifies A/B/Ci for capture this cycle.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- Ci  input  1  carry-in to bit 0.
- S  output  WIDTH  registered sum, (A+B+Ci) mod 2^WIDTH.
- Co  output  1  registered carry-out of the MSB cell.
- out_valid  output  1  high for exactly one cycle per accepted input; S/Co are valid while high.

Behaviour:
- Cell equations, bit i: s_i = a_i ^ b_i ^ c_i; c_(i+1) = (a_i & b_i) | (a_i & c_i) | (b_i & c_i); c_0 = Ci; Co source = c_WIDTH.
- Carry chain is combinational ripple, one cell instance per bit via generate loop. No clocked element inside the chain.
- All state updates on the rising edge of clk only.
- Reset: when rst=1 at an edge: S=0, Co=0, out_valid=0. Reset has priority over in_valid.
- Capture: rst=0 and in_valid=1 at edge N → S, Co, and out_valid=1 visible after edge N. Latency is 1 cycle.
- Idle: rst=0 and in_valid=0 → out_valid=0; S and Co hold their last values.
- Back-to-back: in_valid may be high every cycle; each edge captures a new result. No stall, no backpressure.
- Wrap-around: result exceeding 2^WIDTH-1 wraps in S; the overflow bit appears on Co.
  - Example, WIDTH=8: 0xFF + 0x00 + Ci=1 → S=0x00, Co=1.
- Reset mid-operation: an input presented in the same cycle as rst=1 is discarded. The next cycle shows out_valid=0, S=0, Co=0.
- X-safety: with in_valid=0, unknown A/B/Ci must not propagate into S/Co.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro FULL_ADDER_OVF_EN.
- Defined: adds output port Ov (1 bit) = signed overflow, i.e. c_WIDTH ^ c_(WIDTH-1).
  - For WIDTH=1, Ov = Co ^ Ci.
  - Ov is registered alongside S/Co, resets to 0, and holds when idle.
- Undefined: port Ov does not exist; no additional logic.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, A=1, B=1 → S=0, Co=0, out_valid=0 throughout and one cycle after release.
- WIDTH=1 truth table: apply (A,B,Ci) = 000, 010, 100, 110, 001, 011, 101, 111 on consecutive cycles with in_valid=1.
  - Expected (S,Co) one cycle later: 00, 10, 10, 01, 10, 01, 01, 11.
  - out_valid stays high for all 8 cycles.
- WIDTH=8 wrap: A=0xFF, B=0x01, Ci=0 → S=0x00, Co=1. Then A=0x80, B=0x80, Ci=1 → S=0x01, Co=1. Then A=0x12, B=0x34, Ci=0 → S=0x46, Co=0.
- Hold: capture A=0x0F, B=0x01, Ci=0 (S=0x10), then drop in_valid for 3 cycles while driving A=0xFF, B=0xFF → S stays 0x10, Co stays 0, out_valid=0.
- Reset mid-stream: in_valid=1 continuously with A=0x05, B=0x03; assert rst for 1 cycle → next cycle S=0, Co=0, out_valid=0; following cycle S=0x08, out_valid=1.
- FULL_ADDER_OVF_EN, WIDTH=8: A=0x7F, B=0x01, Ci=0 → S=0x80, Co=0, Ov=1. A=0xFF, B=0x01, Ci=0 → S=0x00, Co=1, Ov=0.
